// File: rtl/mod_ud_counter.sv
// Bounded up/down counter over [0, limit] with wrap or saturate boundary handling,
// a registered boundary pulse (carry) and a sticky boundary flag (overflow).
module mod_ud_counter #(
    parameter int unsigned Size     = 8,
    parameter int unsigned Saturate = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            load,
    input  logic [Size-1:0] data_i,
    input  logic [Size-1:0] limit,
    input  logic            count,
    input  logic            direction,
    output logic [Size-1:0] data_o,
    output logic            at_max,
    output logic            at_zero,
    output logic            carry,
    output logic            overflow
);

    logic [Size-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic            boundary;

    always_comb begin
        cnt_d    = cnt_q;
        boundary = 1'b0;
        carry_d  = 1'b0;
        ovf_d    = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = data_i;
        end else if (count) begin
            if (!direction) begin
                // Values above limit (after a load) also take the boundary path.
                if (cnt_q >= limit) begin
                    boundary = 1'b1;
                    cnt_d    = (Saturate != 0) ? limit : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    boundary = 1'b1;
                    cnt_d    = (Saturate != 0) ? '0 : limit;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            carry_d = boundary;
            ovf_d   = ovf_q | boundary;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o   = cnt_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign at_max   = (cnt_q >= limit);
    assign at_zero  = (cnt_q == '0);

endmodule

// File: tb/tb_mod_ud_counter.sv
// Directed bench: a wrap-mode and a saturate-mode counter (Size=4) share one stimulus stream.
module tb_mod_ud_counter;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear, load, count, direction;
    logic [3:0] data_i, limit;

    logic [3:0] w_data, s_data;
    logic       w_max, w_zero, w_carry, w_ovf;
    logic       s_max, s_zero, s_carry, s_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mod_ud_counter #(.Size(4), .Saturate(0)) u_wrap (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .data_i(data_i),
        .limit(limit), .count(count), .direction(direction), .data_o(w_data),
        .at_max(w_max), .at_zero(w_zero), .carry(w_carry), .overflow(w_ovf)
    );

    mod_ud_counter #(.Size(4), .Saturate(1)) u_sat (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .data_i(data_i),
        .limit(limit), .count(count), .direction(direction), .data_o(s_data),
        .at_max(s_max), .at_zero(s_zero), .carry(s_carry), .overflow(s_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set(input logic c, input logic l, input logic n, input logic d,
                       input logic [3:0] di);
        clear = c; load = l; count = n; direction = d; data_i = di;
    endtask

    initial begin
        reset = 1'b0;
        limit = 4'd0;
        set(0, 0, 0, 0, 4'd0);
        #3;
        check("rst_w_data", w_data, 0);
        check("rst_s_data", s_data, 0);
        check("rst_w_carry", w_carry, 0);
        check("rst_w_ovf", w_ovf, 0);
        check("rst_w_zero", w_zero, 1);
        check("rst_w_max", w_max, 1);
        #9 reset = 1'b1;

        // Wrap up 0..9,0 with limit 9; saturate sticks at 9.
        limit = 4'd9;
        set(0, 0, 1, 0, 4'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            check("up_w_data", w_data, i % 10);
            check("up_w_carry", w_carry, (i == 10) ? 1 : 0);
            check("up_s_data", s_data, (i <= 9) ? i : 9);
            check("up_s_carry", s_carry, (i == 10) ? 1 : 0);
        end
        set(0, 0, 0, 0, 4'd0);
        step();
        check("hold_w_data", w_data, 0);
        check("hold_w_carry", w_carry, 0);
        check("hold_w_ovf", w_ovf, 1);
        check("hold_s_ovf", s_ovf, 1);

        // Wrap down from 0 with limit 5.
        set(1, 0, 0, 0, 4'd0);
        step();
        check("clr_w_ovf", w_ovf, 0);
        limit = 4'd5;
        set(0, 1, 0, 0, 4'd0);
        step();
        check("ld0_w_data", w_data, 0);
        set(0, 0, 1, 1, 4'd0);
        step();
        check("dn1_w_data", w_data, 5);
        check("dn1_w_carry", w_carry, 1);
        check("dn1_s_data", s_data, 0);
        check("dn1_s_carry", s_carry, 1);
        step();
        check("dn2_w_data", w_data, 4);
        check("dn2_w_carry", w_carry, 0);
        check("dn2_s_carry", s_carry, 1);
        step();
        check("dn3_w_data", w_data, 3);

        // Saturate up x6 with limit 3.
        set(1, 0, 0, 0, 4'd0);
        step();
        limit = 4'd3;
        set(0, 0, 1, 0, 4'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check("sat_s_data", s_data, (i < 3) ? i : 3);
            check("sat_s_carry", s_carry, (i > 3) ? 1 : 0);
            check("sat_w_data", w_data, i % 4);
            check("sat_w_carry", w_carry, (i == 4) ? 1 : 0);
        end
        set(1, 0, 0, 0, 4'd0);
        step();
        set(0, 0, 1, 1, 4'd0);
        step();
        check("satdn_s_data", s_data, 0);
        check("satdn_s_carry", s_carry, 1);
        check("satdn_s_ovf", s_ovf, 1);
        check("satdn_w_data", w_data, 3);

        // Priority: clear beats load and count, then load beats count.
        set(1, 1, 1, 0, 4'd7);
        step();
        check("pri_w_data", w_data, 0);
        check("pri_w_ovf", w_ovf, 0);
        check("pri_s_ovf", s_ovf, 0);
        set(0, 1, 1, 0, 4'd7);
        step();
        check("pri_ld_w_data", w_data, 7);
        check("pri_ld_s_data", s_data, 7);
        check("pri_w_max", w_max, 1);
        check("pri_w_zero", w_zero, 0);

        // Out-of-range start above limit.
        limit = 4'd4;
        set(0, 1, 0, 0, 4'd12);
        step();
        check("oor_ld_data", w_data, 12);
        set(0, 0, 1, 0, 4'd0);
        step();
        check("oor_up_w_data", w_data, 0);
        check("oor_up_s_data", s_data, 4);
        check("oor_up_w_carry", w_carry, 1);
        check("oor_up_s_carry", s_carry, 1);
        set(0, 1, 0, 0, 4'd12);
        step();
        check("oor_ld_carry", w_carry, 0);
        set(0, 0, 1, 1, 4'd0);
        step();
        check("oor_dn_w_data", w_data, 11);
        check("oor_dn_s_data", s_data, 11);
        check("oor_dn_carry", w_carry, 0);

        // Limit 0: every count is a boundary event.
        limit = 4'd0;
        set(0, 0, 1, 0, 4'd0);
        step();
        check("l0_w_data", w_data, 0);
        check("l0_s_data", s_data, 0);
        check("l0_carry", s_carry, 1);
        set(0, 0, 1, 1, 4'd0);
        step();
        check("l0dn_w_data", w_data, 0);
        check("l0dn_w_carry", w_carry, 1);

        // Full-range limit behaves as a modulo-16 counter in wrap mode.
        limit = 4'd15;
        set(0, 1, 0, 0, 4'd15);
        step();
        set(0, 0, 1, 0, 4'd0);
        step();
        check("full_w_data", w_data, 0);
        check("full_s_data", s_data, 15);
        check("full_w_carry", w_carry, 1);
        set(0, 1, 0, 0, 4'd0);
        step();
        set(0, 0, 1, 1, 4'd0);
        step();
        check("full_dn_w_data", w_data, 15);

        // Async reset mid-cycle while data_o=6 and overflow=1.
        set(1, 0, 0, 0, 4'd0);
        step();
        limit = 4'd9;
        set(0, 1, 0, 0, 4'd9);
        step();
        set(0, 0, 1, 0, 4'd0);
        step();
        set(0, 1, 0, 0, 4'd5);
        step();
        set(0, 0, 1, 0, 4'd0);
        step();
        check("pre_w_data", w_data, 6);
        check("pre_w_ovf", w_ovf, 1);
        check("pre_s_data", s_data, 6);
        #2 reset = 1'b0;
        #1;
        check("arst_w_data", w_data, 0);
        check("arst_w_ovf", w_ovf, 0);
        check("arst_s_data", s_data, 0);
        check("arst_s_ovf", s_ovf, 0);
        step();
        check("arst_hold_data", w_data, 0);
        #2 reset = 1'b1;
        step();
        check("rel_w_data", w_data, 1);
        check("rel_w_carry", w_carry, 0);
        check("rel_s_data", s_data, 1);
        check("rel_s_carry", s_carry, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_ud_counter.md
MOD_UD_COUNTER -- requirements
Module: mod_ud_counter

Interface
REQ-001 The block SHALL have parameter Size, default 8, meaning the counter width in bits (Size >= 2).
REQ-002 The block SHALL have parameter Saturate, default 0, meaning the boundary mode: 0 = wrap, 1 = saturate.
REQ-003 The block SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port clear  input  1  synchronous clear of counter and flags.
REQ-006 The block SHALL have port load  input  1  synchronous load of data_i.
REQ-007 The block SHALL have port data_i  input  Size  load value.
REQ-008 The block SHALL have port limit  input  Size  inclusive upper bound of the count range [0, limit].
REQ-009 The block SHALL have port count  input  1  count enable.
REQ-010 The block SHALL have port direction  input  1  0 = up, 1 = down.
REQ-011 The block SHALL have port data_o  output  Size  registered count value.
REQ-012 The block SHALL have port at_max  output  1  combinational; high when data_o >= limit (unsigned).
REQ-013 The block SHALL have port at_zero  output  1  combinational; high when data_o == 0.
REQ-014 The block SHALL have port carry  output  1  registered one-cycle boundary-event pulse.
REQ-015 The block SHALL have port overflow  output  1  registered sticky flag; set on any boundary event.

Function
REQ-016 Per-edge priority SHALL be: clear > load > count > hold.
REQ-017 On clear, data_o, carry and overflow SHALL all go to 0 on the next edge.
REQ-018 On load (clear low), data_o SHALL take data_i unmodified, even if data_i > limit; carry SHALL go to 0 and overflow SHALL hold.
REQ-019 On count with direction=0 and data_o < limit, data_o SHALL increment by 1.
REQ-020 On count with direction=0 and data_o >= limit, a boundary event SHALL occur: in wrap mode data_o becomes 0; in saturate mode data_o becomes limit.
REQ-021 On count with direction=1 and data_o != 0, data_o SHALL decrement by 1, including when data_o > limit.
REQ-022 On count with direction=1 and data_o == 0, a boundary event SHALL occur: in wrap mode data_o becomes limit; in saturate mode data_o holds at 0.
REQ-023 carry SHALL be 1 in the cycle after an edge with a boundary event, and 0 after any other edge; consecutive boundary events SHALL keep carry high continuously.
REQ-024 overflow SHALL be set by any boundary event and cleared only by clear or reset.
REQ-025 With limit = 0, every count SHALL be a boundary event: data_o goes to 0 in both modes, carry = 1.
REQ-026 With limit = 2^Size-1, behaviour SHALL equal a plain Size-bit modulo-2^Size up/down counter in wrap mode.
REQ-027 A change of limit SHALL take effect on the same edge; data_o SHALL NOT be adjusted until the next count or load.
REQ-028 All arithmetic SHALL be Size bits unsigned; the +1 and -1 operations SHALL never be used to produce a wrapped value (wrap values come from REQ-020/022 only).
REQ-029 When count=0 and load=0 and clear=0, data_o and overflow SHALL hold and carry SHALL go to 0.

Reset
REQ-030 While reset=0, data_o, carry and overflow SHALL be 0 immediately, independent of clock.
REQ-031 Deassertion of reset SHALL take effect at the first rising clock edge with reset=1; a count asserted during that edge SHALL be honoured.
REQ-032 Reset asserted mid-count SHALL abort the operation, and no carry pulse SHALL appear after release.

Verification (Size=4)
REQ-033 Wrap up: limit=9, count=1, dir=0 from 0 -> data_o 0..9, 0; carry=1 only in the cycle data_o shows the second 0; overflow=1 thereafter.
REQ-034 Wrap down: limit=5, load 0, then count dir=1 -> data_o 5,4,3; carry=1 with the first 5.
REQ-035 Saturate (Saturate=1): limit=3, count up x6 from 0 -> 1,2,3,3,3,3; carry high for the last three cycles; down from 0 -> holds at 0, carry=1.
REQ-036 Priority: clear=1, load=1, count=1 simultaneously, data_i=7 -> data_o=0, overflow=0; then load=1, count=1 -> data_o=7.
REQ-037 Out-of-range: limit=4, load 12, count up -> data_o=0 (wrap) or 4 (saturate), carry=1; load 12, count down -> 11, carry=0.
REQ-038 Async reset: assert reset=0 between edges while data_o=6 and overflow=1 -> data_o=0, overflow=0 before the next edge; release -> counting resumes from 0.
